data_memory_ctrl: RTL and testbench

Parametrised, handshaked data memory for the CPU datapath. It is a byte-addressed, big-endian byte array that supports byte, half-word and word loads and stores, with sign or zero extension on loads. Requests use a valid/ready handshake and complete after a configurable number of wait states, so slower memory timing can be modelled without changing the core. It sits between the ALU result / rs2 path and the write-back mux.

---
 rtl/data_memory_ctrl.sv | 165 ++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_ctrl.sv
// Handshaked big-endian byte-addressed data memory: byte/half/word loads and stores
// with configurable wait states. Define DMEM_MISALIGN_ERR_EN to reject misaligned accesses.
module data_memory_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 0
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    localparam logic [3:0] WS_LAST = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t            state;
    logic [3:0]        cnt;
    logic              we_q, signed_q;
    logic [1:0]        size_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic [7:0] mem [0:(1<<ADDR_W)-1];

    logic              go_resp;
    logic              cur_we, cur_signed;
    logic [1:0]        cur_size;
    logic [ADDR_W-1:0] cur_addr, addr_eff, a0, a1, a2, a3;
    logic [31:0]       cur_wdata, load_data;
    logic              misalign, acc_err;
    logic [7:0]        b0, b1, b2, b3;

    // With no wait states the access happens on the acceptance edge, so it
    // must be taken from the live request rather than the capture registers.
    always_comb begin
        go_resp = 1'b0;
        if (WAIT_STATES == 0)
            go_resp = (state == IDLE) && req_valid;
        else
            go_resp = (state == WAIT) && (cnt == WS_LAST);
    end

    assign cur_we     = (state == IDLE) ? req_we     : we_q;
    assign cur_signed = (state == IDLE) ? req_signed : signed_q;
    assign cur_size   = (state == IDLE) ? req_size   : size_q;
    assign cur_addr   = (state == IDLE) ? req_addr   : addr_q;
    assign cur_wdata  = (state == IDLE) ? req_wdata  : wdata_q;

    always_comb begin
        misalign = 1'b0;
        addr_eff = cur_addr;
`ifdef DMEM_MISALIGN_ERR_EN
        misalign = ((cur_size == 2'b01) && cur_addr[0]) ||
                   ((cur_size == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
        if (cur_size == 2'b01)
            addr_eff = {cur_addr[ADDR_W-1:1], 1'b0};
        else if (cur_size == 2'b10)
            addr_eff = {cur_addr[ADDR_W-1:2], 2'b00};
`endif
    end

    assign acc_err = (cur_size == 2'b11) || misalign;

    assign a0 = addr_eff;
    assign a1 = addr_eff + ADDR_W'(1);
    assign a2 = addr_eff + ADDR_W'(2);
    assign a3 = addr_eff + ADDR_W'(3);
    assign b0 = mem[a0];
    assign b1 = mem[a1];
    assign b2 = mem[a2];
    assign b3 = mem[a3];

    always_comb begin
        load_data = '0;
        case (cur_size)
            2'b00:   load_data = {{24{cur_signed & b0[7]}}, b0};
            2'b01:   load_data = {{16{cur_signed & b0[7]}}, b0, b1};
            2'b10:   load_data = {b0, b1, b2, b3};
            default: load_data = '0;
        endcase
    end

    // Array is deliberately not reset; a reset on the commit edge drops the store.
    always_ff @(posedge CLK) begin
        if (!Reset && go_resp && cur_we && !acc_err) begin
            case (cur_size)
                2'b00: mem[a0] <= cur_wdata[7:0];
                2'b01: begin
                    mem[a0] <= cur_wdata[15:8];
                    mem[a1] <= cur_wdata[7:0];
                end
                2'b10: begin
                    mem[a0] <= cur_wdata[31:24];
                    mem[a1] <= cur_wdata[23:16];
                    mem[a2] <= cur_wdata[15:8];
                    mem[a3] <= cur_wdata[7:0];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            we_q      <= 1'b0;
            signed_q  <= 1'b0;
            size_q    <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            rsp_valid <= go_resp;
            rsp_err   <= go_resp && acc_err;
            rsp_rdata <= (go_resp && !acc_err && !cur_we) ? load_data : 32'd0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        signed_q  <= req_signed;
                        size_q    <= req_size;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        cnt       <= '0;
                        req_ready <= 1'b0;
                        state     <= (WAIT_STATES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == WS_LAST) begin
                        cnt   <= '0;
                        state <= RESP;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

    assign busy = ~req_ready;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl: one instance with no wait states, one with three.
module tb_data_memory_ctrl;
    logic        CLK = 1'b0;
    logic        Reset;
    logic        v0, v3;
    logic        b_we, b_sgn;
    logic [1:0]  b_size;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata;
    logic        rdy0, rv0, er0, busy0;
    logic        rdy3, rv3, er3, busy3;
    logic [31:0] rd0, rd3;

    int n_vec = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    data_memory_ctrl #(.ADDR_W(8), .WAIT_STATES(0)) d0 (
        .CLK(CLK), .Reset(Reset), .req_valid(v0), .req_ready(rdy0), .req_we(b_we),
        .req_size(b_size), .req_signed(b_sgn), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0), .busy(busy0));

    data_memory_ctrl #(.ADDR_W(8), .WAIT_STATES(3)) d3 (
        .CLK(CLK), .Reset(Reset), .req_valid(v3), .req_ready(rdy3), .req_we(b_we),
        .req_size(b_size), .req_signed(b_sgn), .req_addr(b_addr), .req_wdata(b_wdata),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3), .busy(busy3));

    // One request on the chosen instance; returns the response and its latency in cycles.
    task automatic issue(input bit which, input bit we, input logic [1:0] sz, input bit sgn,
                         input logic [7:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int lat);
        @(negedge CLK);
        b_we = we; b_size = sz; b_sgn = sgn; b_addr = a; b_wdata = wd;
        if (which) v3 = 1'b1; else v0 = 1'b1;
        @(posedge CLK);
        #1;
        v0 = 1'b0; v3 = 1'b0;
        lat = -1; rd = 'x; er = 1'bx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge CLK);
            if (which ? rv3 : rv0) begin
                lat = k;
                rd  = which ? rd3 : rd0;
                er  = which ? er3 : er0;
                break;
            end
        end
        if (lat < 0) begin
            n_vec++; n_err++;
            $display("FAIL rsp_timeout dut=%0d addr=%h: no rsp_valid within 20 cycles", which, a);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1; v0 = 0; v3 = 0;
        b_we = 0; b_size = 0; b_sgn = 0; b_addr = 0; b_wdata = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            n_vec++;
            if ({rdy0, rv0, busy0, er0, rd0} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
                n_err++;
                $display("FAIL reset_idle_d0 cyc=%0d got rdy=%b v=%b busy=%b err=%b rd=%h want 1 0 0 0 0",
                         k, rdy0, rv0, busy0, er0, rd0);
            end
            n_vec++;
            if ({rdy3, rv3, busy3, er3, rd3} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'd0}) begin
                n_err++;
                $display("FAIL reset_idle_d3 cyc=%0d got rdy=%b v=%b busy=%b err=%b rd=%h want 1 0 0 0 0",
                         k, rdy3, rv3, busy3, er3, rd3);
            end
        end
    endtask

    task automatic test_ws0_access();
        logic [31:0] rd; logic er; int lat;
        logic [1:0]  sz  [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b11};
        bit          we  [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
        bit          sg  [8] = '{0, 1, 0, 0, 0, 1, 1, 1};
        logic [7:0]  ad  [8] = '{8'h10, 8'h10, 8'h12, 8'h11, 8'h10, 8'h11, 8'h12, 8'h10};
        logic [31:0] wd  [8] = '{32'hDEADBEEF, 0, 0, 32'h0000007F, 0, 0, 0, 0};
        logic [31:0] exd [8] = '{32'h0, 32'hFFFFFFDE, 32'h0000BEEF, 32'h0,
                                 32'hDE7FBEEF, 32'h0000007F, 32'hFFFFBEEF, 32'h0};
        bit          exe [8] = '{0, 0, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            issue(1'b0, we[i], sz[i], sg[i], ad[i], wd[i], rd, er, lat);
            n_vec++;
            if (lat != 1) begin
                n_err++;
                $display("FAIL ws0_latency vec=%0d got %0d want 1", i, lat);
            end
            n_vec++;
            if (rd !== exd[i] || er !== exe[i]) begin
                n_err++;
                $display("FAIL ws0_data vec=%0d got rd=%h err=%b want rd=%h err=%b", i, rd, er, exd[i], exe[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int lat;
        issue(1'b1, 1'b1, 2'b10, 1'b0, 8'h20, 32'h11223344, rd, er, lat);
        n_vec++;
        if (lat != 4 || rd !== 32'd0 || er !== 1'b0) begin
            n_err++;
            $display("FAIL ws3_store got lat=%0d rd=%h err=%b want 4 0 0", lat, rd, er);
        end
        // Load with req_valid held through the whole busy window.
        @(negedge CLK);
        b_we = 0; b_size = 2'b10; b_sgn = 0; b_addr = 8'h20; v3 = 1'b1;
        @(posedge CLK);
        for (int k = 1; k <= 4; k++) begin
            @(negedge CLK);
            n_vec++;
            if (rdy3 !== 1'b0 || busy3 !== 1'b1 || rv3 !== (k == 4)) begin
                n_err++;
                $display("FAIL ws3_window t+%0d got rdy=%b busy=%b v=%b want 0 1 %0d", k, rdy3, busy3, rv3, k == 4);
            end
            if (k == 4) begin
                v3 = 1'b0;
                n_vec++;
                if (rd3 !== 32'h11223344) begin
                    n_err++;
                    $display("FAIL ws3_load got %h want 11223344", rd3);
                end
            end
        end
        for (int k = 5; k <= 9; k++) begin
            @(negedge CLK);
            n_vec++;
            if (rdy3 !== 1'b1 || rv3 !== 1'b0) begin
                n_err++;
                $display("FAIL ws3_no_second_accept t+%0d got rdy=%b v=%b want 1 0", k, rdy3, rv3);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge CLK);
        b_we = 0; b_size = 2'b00; b_sgn = 0; b_addr = 8'h10; v0 = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge CLK);
            n_vec++;
            if (rv0 !== (k % 2 == 1) || rdy0 !== (k % 2 == 0)) begin
                n_err++;
                $display("FAIL b2b cyc=%0d got v=%b rdy=%b want %0d %0d", k, rv0, rdy0, k % 2 == 1, k % 2 == 0);
            end
        end
        v0 = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        @(negedge CLK);
        b_we = 1; b_size = 2'b10; b_sgn = 0; b_addr = 8'h20; b_wdata = 32'h12345678; v3 = 1'b1;
        @(posedge CLK);
        #1 v3 = 1'b0;
        @(negedge CLK);
        Reset = 1'b1;
        @(negedge CLK);
        n_vec++;
        if (rv3 !== 1'b0 || rdy3 !== 1'b1) begin
            n_err++;
            $display("FAIL abort_in_reset got v=%b rdy=%b want 0 1", rv3, rdy3);
        end
        Reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            n_vec++;
            if (rv3 !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_rsp cyc=%0d got v=%b want 0", k, rv3);
            end
        end
        issue(1'b1, 1'b0, 2'b10, 1'b0, 8'h20, 32'd0, rd, er, lat);
        n_vec++;
        if (rd !== 32'h11223344 || er !== 1'b0) begin
            n_err++;
            $display("FAIL abort_mem got rd=%h err=%b want 11223344 0", rd, er);
        end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat;
        bit          exp_er;
        logic [31:0] exp_w, exp_h;
`ifdef DMEM_MISALIGN_ERR_EN
        exp_er = 1'b1; exp_w = 32'hAABBCCDD; exp_h = 32'd0;
`else
        exp_er = 1'b0; exp_w = 32'h01020304; exp_h = 32'h0000BEEF;
`endif
        issue(1'b0, 1'b1, 2'b10, 1'b0, 8'h20, 32'hAABBCCDD, rd, er, lat);
        issue(1'b0, 1'b1, 2'b10, 1'b0, 8'h21, 32'h01020304, rd, er, lat);
        n_vec++;
        if (er !== exp_er || rd !== 32'd0 || lat != 1) begin
            n_err++;
            $display("FAIL misalign_store got err=%b rd=%h lat=%0d want %b 0 1", er, rd, lat, exp_er);
        end
        issue(1'b0, 1'b0, 2'b10, 1'b0, 8'h20, 32'd0, rd, er, lat);
        n_vec++;
        if (rd !== exp_w || er !== 1'b0) begin
            n_err++;
            $display("FAIL misalign_mem got rd=%h err=%b want %h 0", rd, er, exp_w);
        end
        issue(1'b0, 1'b0, 2'b01, 1'b0, 8'h13, 32'd0, rd, er, lat);
        n_vec++;
        if (rd !== exp_h || er !== exp_er) begin
            n_err++;
            $display("FAIL misalign_half got rd=%h err=%b want %h %b", rd, er, exp_h, exp_er);
        end
        issue(1'b0, 1'b1, 2'b11, 1'b0, 8'h20, 32'hFFFFFFFF, rd, er, lat);
        n_vec++;
        if (rd !== 32'd0 || er !== 1'b1 || lat != 1) begin
            n_err++;
            $display("FAIL reserved_store got rd=%h err=%b lat=%0d want 0 1 1", rd, er, lat);
        end
        issue(1'b0, 1'b0, 2'b10, 1'b0, 8'h20, 32'd0, rd, er, lat);
        n_vec++;
        if (rd !== exp_w) begin
            n_err++;
            $display("FAIL reserved_no_write got %h want %h", rd, exp_w);
        end
        issue(1'b1, 1'b0, 2'b11, 1'b1, 8'h20, 32'd0, rd, er, lat);
        n_vec++;
        if (rd !== 32'd0 || er !== 1'b1 || lat != 4) begin
            n_err++;
            $display("FAIL reserved_ws3 got rd=%h err=%b lat=%0d want 0 1 4", rd, er, lat);
        end
        @(negedge CLK);
        n_vec++;
        if (er3 !== 1'b0 || er0 !== 1'b0) begin
            n_err++;
            $display("FAIL err_clear got d0=%b d3=%b want 0 0", er0, er3);
        end
    endtask

    initial begin
        test_reset();
        test_ws0_access();
        test_wait_states();
        test_back_to_back();
        test_reset_abort();
        test_misalign();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
